input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Front-end stage that feeds the two-input state controller. It turns two raw, asynchronous switch/button inputs into the clean, single-clock-domain X and Y levels the controller samples every clock.
- Each channel has a 2-flop synchronizer, a stability-count debouncer, and an optional rising-edge pulse generator.
- A shared strobe flags any change of a debounced level.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles the synchronized input must differ from the debounced level before the level flips; legal range >= 1.
- CNT_W, 3: width of each stability counter; must hold DEBOUNCE_CYCLES-1.
- PULSE_MODE, 0: 0 = X/Y are debounced levels; 1 = X/Y are one-cycle pulses on debounced rising edges.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- x_raw  in  1  raw asynchronous input for channel X
- y_raw  in  1  raw asynchronous input for channel Y
- X  out  1  conditioned X to controller (registered)
- Y  out  1  conditioned Y to controller (registered)
- changed  out  1  one-cycle strobe when either debounced level changes (registered)

Behaviour:
- Reset values: sync flops s1/s2 = 0; debounced level d = 0; counter cnt = 0; X, Y, changed = 0. Reset is async: outputs drop to 0 without waiting for a clock edge.
- Synchronizer, every edge: s1 <= raw, s2 <= s1.
- Debouncer, every edge:
  - if s2 == d: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: d <= s2, cnt <= 0.
  - else: cnt <= cnt+1.
  - cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
- Latency: raw changes and is held. Call the first edge that samples it into s1 edge 0. Then d changes at edge DEBOUNCE_CYCLES+1.
  - DEBOUNCE_CYCLES=4: edge 5.
  - DEBOUNCE_CYCLES=1: edge 2.
- Glitch rejection: if s2 returns to d before the count completes, cnt clears and d is unchanged. A later change restarts the count from 0.
- Level mode (PULSE_MODE=0): X/Y are updated at the same edge as d, so they equal the channel's d.
- Pulse mode (PULSE_MODE=1):
  - X/Y go to 1 at the edge where d goes 0->1, and return to 0 at the next edge.
  - A 1->0 transition of d produces no pulse.
  - Continuous high produces exactly one pulse.
- changed: set to 1 at any edge where either channel's d updates, cleared at the next edge. If both channels update at the same edge, one single-cycle strobe is produced.
- The two channels are fully independent; simultaneous activity on both needs no arbitration.
- Reset mid-operation:
  - Partial counts are discarded and d returns to 0.
  - A raw input held high across reset release is treated as a fresh change from the first edge after release.
- No combinational path from x_raw/y_raw to any output.

Decomposition:
- Sub-module debounce_channel: synchronizer + counter + level register + edge detect for one input. Parameterized by DEBOUNCE_CYCLES and CNT_W. Outputs the level, a rise pulse and an update strobe.
- input_conditioner instantiates debounce_channel twice and does output muxing by PULSE_MODE plus the changed OR/register.
- Shared include file: default DEBOUNCE_CYCLES constant, reused by the bench and the top level. No typedefs needed.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- Reset: hold reset with x_raw=y_raw=1 for 10 cycles -> X=Y=changed=0 throughout. Assert reset between edges while X=1 -> X drops to 0 before the next edge.
- Single rise: x_raw 0->1 before edge 0, held -> X=1 from edge 5; changed=1 only for edge 5->6; Y stays 0. x_raw 1->0 later -> X=0 exactly 5 edges after the sampling edge.
- Glitch: x_raw high for 3 sampling edges (edges 0-2) then low -> X and changed never assert. A 4-edge pulse (edges 0-3) -> X asserts at edge 5.
- Simultaneous: x_raw and y_raw rise together -> X and Y both rise at edge 5; changed is a single one-cycle strobe.
- Pulse mode (PULSE_MODE=1): x_raw high for 20 cycles then low -> X=1 only in the cycle after edge 5. No pulse on the fall, but changed strobes on both the rise and the fall.
- Reset mid-count: x_raw held high, reset pulsed between edges 3 and 4 -> X stays 0 at edge 5. X rises at edge 5 counted from the first edge after reset release. Also run DEBOUNCE_CYCLES=1 -> X rises at edge 2.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared constants for the input conditioner and anything that drives it.
// The default debounce length lives here so the top level and benches agree.
package input_conditioner_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int CNT_W_DEFAULT           = 3;
  localparam int NUM_CHANNELS            = 2;

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: 2-flop synchronizer, stability-count debouncer,
// level register and registered rising-edge pulse.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic update
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_reg;
  logic             s2_reg;
  logic             d_reg;
  logic             d_next;
  logic             rise_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             flip;

  // The counter only runs while the synchronized input disagrees with the
  // debounced level; any agreement discards the partial count.
  always_comb begin
    flip     = 1'b0;
    d_next   = d_reg;
    cnt_next = '0;
    if (s2_reg != d_reg) begin
      if (cnt_reg == CNT_MAX) begin
        flip   = 1'b1;
        d_next = s2_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_reg   <= 1'b0;
      s2_reg   <= 1'b0;
      d_reg    <= 1'b0;
      cnt_reg  <= '0;
      rise_reg <= 1'b0;
    end else begin
      s1_reg   <= raw;
      s2_reg   <= s1_reg;
      d_reg    <= d_next;
      cnt_reg  <= cnt_next;
      rise_reg <= flip & s2_reg;
    end
  end

  assign level  = d_reg;
  assign rise   = rise_reg;
  // Asserted in the cycle before the level flips, so the parent can
  // register its strobe on the same edge as the level change.
  assign update = flip;

endmodule

// File: rtl/input_conditioner.sv
// Conditions two raw asynchronous inputs into clean X/Y levels (or rising
// pulses) for the state controller, plus a shared change strobe.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT,
  parameter int PULSE_MODE      = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic x_raw,
  input  logic y_raw,
  output logic X,
  output logic Y,
  output logic changed
);

  logic [NUM_CHANNELS-1:0] raw_vec;
  logic [NUM_CHANNELS-1:0] level_vec;
  logic [NUM_CHANNELS-1:0] rise_vec;
  logic [NUM_CHANNELS-1:0] update_vec;
  logic [NUM_CHANNELS-1:0] out_vec;
  logic                    changed_reg;

  assign raw_vec = {y_raw, x_raw};

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_chan (
        .clock (clock),
        .reset (reset),
        .raw   (raw_vec[gi]),
        .level (level_vec[gi]),
        .rise  (rise_vec[gi]),
        .update(update_vec[gi])
      );
    end
  endgenerate

  // Both sources are channel registers, so X/Y stay glitch-free and have no
  // combinational path from the raw pins.
  assign out_vec = (PULSE_MODE != 0) ? rise_vec : level_vec;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      changed_reg <= 1'b0;
    end else begin
      changed_reg <= |update_vec;
    end
  end

  assign X       = out_vec[0];
  assign Y       = out_vec[1];
  assign changed = changed_reg;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: level mode, pulse mode and a
// single-cycle debounce instance share the same raw inputs.
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  localparam int NV = 44;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic x_raw = 1'b0;
  logic y_raw = 1'b0;

  logic lv_x, lv_y, lv_chg;
  logic pl_x, pl_y, pl_chg;
  logic d1_x, d1_y, d1_chg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_DEFAULT), .CNT_W(3), .PULSE_MODE(0)) u_level (
    .clock(clock), .reset(reset), .x_raw(x_raw), .y_raw(y_raw),
    .X(lv_x), .Y(lv_y), .changed(lv_chg)
  );

  input_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_DEFAULT), .CNT_W(3), .PULSE_MODE(1)) u_pulse (
    .clock(clock), .reset(reset), .x_raw(x_raw), .y_raw(y_raw),
    .X(pl_x), .Y(pl_y), .changed(pl_chg)
  );

  input_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(3), .PULSE_MODE(0)) u_d1 (
    .clock(clock), .reset(reset), .x_raw(x_raw), .y_raw(y_raw),
    .X(d1_x), .Y(d1_y), .changed(d1_chg)
  );

  typedef struct packed {
    logic x;    // x_raw driven before this edge
    logic y;    // y_raw driven before this edge
    logic lx;   // level-mode X after the edge
    logic ly;
    logic lc;
    logic px;   // pulse-mode X after the edge
    logic py;
    logic pc;
    logic d1x;  // DEBOUNCE_CYCLES=1 X after the edge
  } vec_t;

  vec_t vecs [NV];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b, want %0b", name, act, exp);
    end
  endtask

  initial begin
    // Columns, index 0 leftmost. Segments: rise (0-7), fall (8-15),
    // 3-edge glitch (16-23), 4-edge pulse (24-35), both rise (36-43).
    logic [0:NV-1] x_pat  = 44'b11111111_00000000_11100000_11110000_00001111_1111;
    logic [0:NV-1] y_pat  = 44'b00000000_00000000_00000000_00000000_00001111_1111;
    logic [0:NV-1] lx_pat = 44'b00000111_11111000_00000000_00000111_10000000_0111;
    logic [0:NV-1] ly_pat = 44'b00000000_00000000_00000000_00000000_00000000_0111;
    logic [0:NV-1] lc_pat = 44'b00000100_00000100_00000000_00000100_01000000_0100;
    logic [0:NV-1] px_pat = 44'b00000100_00000000_00000000_00000100_00000000_0100;
    logic [0:NV-1] py_pat = 44'b00000000_00000000_00000000_00000000_00000000_0100;

    for (int k = 0; k < NV; k++) begin
      vecs[k].x   = x_pat[k];
      vecs[k].y   = y_pat[k];
      vecs[k].lx  = lx_pat[k];
      vecs[k].ly  = ly_pat[k];
      vecs[k].lc  = lc_pat[k];
      vecs[k].px  = px_pat[k];
      vecs[k].py  = py_pat[k];
      vecs[k].pc  = lc_pat[k];
      vecs[k].d1x = (k >= 2) ? x_pat[k-2] : 1'b0;
    end

    repeat (2) tick();
    reset = 1'b0;
    check("reset_lv_x", lv_x, 1'b0);
    check("reset_lv_chg", lv_chg, 1'b0);
    check("reset_pl_x", pl_x, 1'b0);

    for (int k = 0; k < NV; k++) begin
      x_raw = vecs[k].x;
      y_raw = vecs[k].y;
      tick();
      check($sformatf("v%0d lv_x", k), lv_x, vecs[k].lx);
      check($sformatf("v%0d lv_y", k), lv_y, vecs[k].ly);
      check($sformatf("v%0d lv_chg", k), lv_chg, vecs[k].lc);
      check($sformatf("v%0d pl_x", k), pl_x, vecs[k].px);
      check($sformatf("v%0d pl_y", k), pl_y, vecs[k].py);
      check($sformatf("v%0d pl_chg", k), pl_chg, vecs[k].pc);
      check($sformatf("v%0d d1_x", k), d1_x, vecs[k].d1x);
    end

    // Async reset between edges while X=Y=1
    check("pre_async_lv_x", lv_x, 1'b1);
    reset = 1'b1;
    #1;
    check("async_lv_x", lv_x, 1'b0);
    check("async_lv_y", lv_y, 1'b0);
    check("async_d1_x", d1_x, 1'b0);

    // Held reset with inputs high
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("hold%0d lv_x", i), lv_x, 1'b0);
      check($sformatf("hold%0d lv_y", i), lv_y, 1'b0);
      check($sformatf("hold%0d lv_chg", i), lv_chg, 1'b0);
      check($sformatf("hold%0d pl_x", i), pl_x, 1'b0);
      check($sformatf("hold%0d pl_chg", i), pl_chg, 1'b0);
      check($sformatf("hold%0d d1_x", i), d1_x, 1'b0);
    end

    // Inputs high across release count as a fresh change
    reset = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      tick();
      check($sformatf("rel_e%0d lv_x", e), lv_x, (e >= 5));
      check($sformatf("rel_e%0d lv_y", e), lv_y, (e >= 5));
      check($sformatf("rel_e%0d lv_chg", e), lv_chg, (e == 5));
      check($sformatf("rel_e%0d pl_x", e), pl_x, (e == 5));
      check($sformatf("rel_e%0d d1_x", e), d1_x, (e >= 2));
    end

    // Reset pulsed mid-count discards the partial count
    reset = 1'b1;
    x_raw = 1'b0;
    y_raw = 1'b0;
    tick();
    reset = 1'b0;
    x_raw = 1'b1;
    repeat (4) tick();
    check("mid_pre_lv_x", lv_x, 1'b0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      tick();
      check($sformatf("mid_e%0d lv_x", e), lv_x, (e >= 5));
      check($sformatf("mid_e%0d lv_y", e), lv_y, 1'b0);
      check($sformatf("mid_e%0d lv_chg", e), lv_chg, (e == 5));
      check($sformatf("mid_e%0d d1_x", e), d1_x, (e >= 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
